uart_rx_deser: RTL and testbench

- Receive-side UART deserializer on the sysclk domain (12 MHz).
- Sits between the board uart_rx pin and the top-level command/response logic in main.
- Converts 8N1 serial frames into bytes and presents them on a valid/ready holding register.
- Flags framing errors and overruns as one-cycle pulses.

---
 rtl/uart_rx_deser.sv | 205 ++++++++++++++++++++
 tb/tb_uart_rx_deser.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deser.sv
// rtl/uart_rx_deser.sv - 8N1 UART receive deserializer with valid/ready holding register
//
// Purpose:
//   Samples the asynchronous uart_rx line on sysclk, recovers 8N1 frames
//   (LSB first) using mid-bit sampling, and presents each good byte in a
//   single-entry holding register. Framing errors and overruns are reported
//   as one-cycle pulses.
//
// Optional feature (macro UART_RX_PARITY_EN):
//   Adds an even-parity bit between the data bits and the stop bit, and the
//   parity_err output pulse that accompanies delivery of a byte whose parity
//   bit did not match.
//
// Ports:
//   sysclk     in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   uart_rx    in   raw serial line, idle high, asynchronous to sysclk
//   rx_ready   in   consumer accepts rx_data when rx_valid & rx_ready
//   rx_data    out  [7:0] received byte, stable while rx_valid and not accepted
//   rx_valid   out  holding register full
//   frame_err  out  one-cycle pulse: stop bit sampled low
//   overrun    out  one-cycle pulse: byte completed while holding register full
//   busy       out  receiver is not idle
//   parity_err out  one-cycle pulse with delivery on parity mismatch (UART_RX_PARITY_EN only)

module uart_rx_deser #(
  parameter int CLK_FREQ = 12000000,
  parameter int BAUD     = 115200
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic       uart_rx,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t        state_q;
  logic          rx_meta_q;
  logic          rx_s_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic          rearm_q;
  logic          stop_seen_q;
  logic          stop_bit_q;
  logic [7:0]    rx_data_q;
  logic          rx_valid_q;
  logic          frame_err_q;
  logic          overrun_q;
`ifdef UART_RX_PARITY_EN
  logic          parity_bad_q;
  logic          parity_err_q;
`endif

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      rearm_q      <= 1'b1;
      stop_seen_q  <= 1'b0;
      stop_bit_q   <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad_q <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_meta_q   <= uart_rx;
      rx_s_q      <= rx_meta_q;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      // Consumer handshake; a delivery later in this block overrides the clear.
      if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          // After a break the line must be seen high before a new start is accepted.
          if (rx_s_q) begin
            rearm_q <= 1'b1;
          end else if (rearm_q) begin
            state_q <= S_START;
            cnt_q   <= HALF_LOAD;
          end
        end

        S_START: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (!rx_s_q) begin
            state_q   <= S_DATA;
            bit_idx_q <= '0;
            cnt_q     <= FULL_LOAD;
          end else begin
            state_q <= S_IDLE;
          end
        end

        S_DATA: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            shift_q   <= {rx_s_q, shift_q[7:1]};
            cnt_q     <= FULL_LOAD;
            bit_idx_q <= bit_idx_q + 1'b1;
            if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_q <= S_PARITY;
`else
              state_q <= S_STOP;
`endif
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            // Even parity: data bits plus parity bit must XOR to zero.
            parity_bad_q <= ^{rx_s_q, shift_q};
            cnt_q        <= FULL_LOAD;
            state_q      <= S_STOP;
          end
        end
`endif

        S_STOP: begin
          // Sample the stop bit, then resolve delivery on the following cycle.
          if (!stop_seen_q) begin
            if (cnt_q != '0) begin
              cnt_q <= cnt_q - 1'b1;
            end else begin
              stop_seen_q <= 1'b1;
              stop_bit_q  <= rx_s_q;
            end
          end else begin
            stop_seen_q <= 1'b0;
            state_q     <= S_IDLE;
            if (stop_bit_q) begin
              if (!rx_valid_q || rx_ready) begin
                rx_data_q  <= shift_q;
                rx_valid_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
                parity_err_q <= parity_bad_q;
`endif
              end else begin
                overrun_q <= 1'b1;
              end
            end else begin
              frame_err_q <= 1'b1;
              rearm_q     <= 1'b0;
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_deser.sv
// tb/tb_uart_rx_deser.sv - scoreboard testbench for uart_rx_deser

module tb_uart_rx_deser;

  localparam int BIT = 12000000 / 115200;

  logic       sysclk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_rx = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  always #5 sysclk = ~sysclk;

  uart_rx_deser dut (
    .sysclk    (sysclk),
    .rst       (rst),
    .uart_rx   (uart_rx),
    .rx_ready  (rx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .overrun   (overrun),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy      (busy)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  int  exp_fe = 0;
  int  exp_ov = 0;
  int  fe_cnt = 0;
  int  ov_cnt = 0;
  bit  hold_full = 1'b0;

  int  cyc = 0;
  int  busy_rise = 0;
  int  valid_rise = 0;
  logic busy_prev = 1'b0;
  logic valid_prev = 1'b0;
  logic stall_prev = 1'b0;
  logic [7:0] data_prev = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted byte, counts pulses.
  always @(negedge sysclk) begin
    cyc++;
    if (rst) begin
      busy_prev  = 1'b0;
      valid_prev = 1'b0;
      stall_prev = 1'b0;
    end else begin
      if (busy && !busy_prev) busy_rise = cyc;
      if (rx_valid && !valid_prev) valid_rise = cyc;
      if (stall_prev && rx_valid) check("data_stable", rx_data, data_prev);
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got 0x%0h, expected no byte", rx_data);
        end else begin
          check("rx_data", rx_data, exp_q.pop_front());
        end
      end
      stall_prev = rx_valid && !rx_ready;
      data_prev  = rx_data;
      busy_prev  = busy;
      valid_prev = rx_valid;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  // Reference model: decides the outcome of a frame from the line contents
  // and the consumer state, then drives the frame onto the line.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    if (!stop_ok) exp_fe++;
    else if (rx_ready) exp_q.push_back(b);
    else if (hold_full) exp_ov++;
    else begin
      exp_q.push_back(b);
      hold_full = 1'b1;
    end
    uart_rx = 1'b0;
    idle(BIT);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      idle(BIT);
    end
`ifdef UART_RX_PARITY_EN
    uart_rx = ^b;
    idle(BIT);
`endif
    uart_rx = stop_ok;
    idle(BIT);
    uart_rx = 1'b1;
  endtask

  task automatic set_ready(input bit r);
    rx_ready = r;
    if (r && hold_full) begin
      hold_full = 1'b0;
      idle(2);
    end
  endtask

  initial begin
    int lat;
    int waited;
    logic [7:0] b;
    bit ok;

    idle(3);
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_rx_valid", rx_valid, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_frame_err", frame_err, 1'b0);
    check("reset_overrun", overrun, 1'b0);
    rst = 1'b0;
    idle(20);

    // Single byte, latency from start detection to delivery.
    set_ready(1'b1);
    send_frame(8'h55, 1'b1);
    idle(20);
    lat = valid_rise - busy_rise;
    checks++;
    if (lat < 987 || lat > 991) begin
      errors++;
      $display("FAIL latency: got %0d cycles, expected 989 +/- 2", lat);
    end
    check("t1_frame_err", fe_cnt, exp_fe);
    check("t1_overrun", ov_cnt, exp_ov);
    check("t1_drained", exp_q.size(), 0);

    // Overrun while the holding register is full.
    set_ready(1'b0);
    send_frame(8'hA3, 1'b1);
    send_frame(8'h3C, 1'b1);
    idle(10);
    check("ovr_rx_valid", rx_valid, 1'b1);
    check("ovr_rx_data", rx_data, 8'hA3);
    check("ovr_count", ov_cnt, 1);
    set_ready(1'b1);
    check("ovr_drain_valid", rx_valid, 1'b0);
    check("ovr_drained", exp_q.size(), 0);

    // Framing error, then a break: only one frame_err.
    send_frame(8'hF0, 1'b0);
    uart_rx = 1'b0;
    idle(2000);
    check("brk_frame_err", fe_cnt, 1);
    check("brk_rx_valid", rx_valid, 1'b0);
    uart_rx = 1'b1;
    idle(10);
    send_frame(8'h0F, 1'b1);
    idle(20);
    check("brk_recover", exp_q.size(), 0);

    // Short glitch: start check rejects it.
    uart_rx = 1'b0;
    idle(30);
    uart_rx = 1'b1;
    idle(10);
    check("glitch_busy_hi", busy, 1'b1);
    waited = 0;
    while (busy && waited < 200) begin
      idle(1);
      waited++;
    end
    check("glitch_busy_lo", busy, 1'b0);
    check("glitch_frame_err", fe_cnt, exp_fe);
    check("glitch_rx_valid", rx_valid, 1'b0);

    // Reset mid-frame discards held and partial bytes.
    set_ready(1'b0);
    send_frame(8'h5A, 1'b1);
    idle(10);
    check("pre_rst_valid", rx_valid, 1'b1);
    uart_rx = 1'b0;
    idle(BIT);
    for (int i = 0; i < 4; i++) begin
      uart_rx = 1'b1;
      idle(BIT);
    end
    idle(BIT / 2);
    check("pre_rst_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_rx_valid", rx_valid, 1'b0);
    exp_q.delete();
    hold_full = 1'b0;
    idle(2);
    rst = 1'b0;
    idle(BIT * 6);
    set_ready(1'b1);
    send_frame(8'h81, 1'b1);
    idle(20);
    check("post_rst_drained", exp_q.size(), 0);

    // Randomized frames, consumer readiness and stop-bit errors.
    for (int n = 0; n < 20; n++) begin
      set_ready(1'($urandom_range(0, 1)));
      b  = 8'($urandom);
      ok = ($urandom_range(0, 7) != 0);
      send_frame(b, ok);
      idle(ok ? $urandom_range(0, 30) : $urandom_range(5, 30));
    end
    set_ready(1'b1);
    idle(20);
    check("final_drained", exp_q.size(), 0);
    check("final_frame_err", fe_cnt, exp_fe);
    check("final_overrun", ov_cnt, exp_ov);
    check("final_rx_valid", rx_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
